// File: rtl/c_fetch_align_queue.sv
// c_fetch_align_queue: RV32IC fetch sequencer; word fetches feed a halfword queue
// that realigns 16/32-bit instructions and supports redirects to any halfword PC.
module c_fetch_align_queue #(
    parameter int          DEPTH_HW = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_is_compressed
);
    localparam int PW = $clog2(DEPTH_HW);
    localparam int CW = $clog2(DEPTH_HW + 1);

    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_KILL} state_t;

    state_t        state, state_nx;
    logic [15:0]   q [DEPTH_HW];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nx1, wr_nx1;
    logic [CW-1:0] count, push_n, pop_n;
    logic [31:0]   fetch_addr, head_pc;
    logic [15:0]   hw0, hw1;
    logic          drop_low, accept, push, pop, is32;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int n);
        return PW'((int'(p) + n) % DEPTH_HW);
    endfunction

    assign rd_nx1 = wrap_add(rd_ptr, 1);
    assign wr_nx1 = wrap_add(wr_ptr, 1);
    assign hw0    = q[rd_ptr];
    assign hw1    = q[rd_nx1];
    assign is32   = hw0[1:0] == 2'b11;

    // A 32-bit instruction split across words waits until both halves are queued
    assign inst_valid         = is32 ? count >= CW'(2) : count != '0;
    assign inst_data          = !inst_valid ? 32'h0 : is32 ? {hw1, hw0} : {16'h0, hw0};
    assign inst_is_compressed = inst_valid && !is32;
    assign inst_pc            = head_pc;
    assign imem_addr          = fetch_addr;

    assign pop    = inst_valid && inst_ready && !flush;
    assign accept = imem_req_valid && imem_req_ready;
    assign pop_n  = !pop ? '0 : is32 ? CW'(2) : CW'(1);
    assign push_n = !push ? '0 : drop_low ? CW'(1) : CW'(2);

    // Issuing only with two free slots reserves room for the single outstanding response
    always_comb begin
        state_nx       = state;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        case (state)
            F_IDLE: begin
                imem_req_valid = reset_n && !flush && int'(count) <= DEPTH_HW - 2;
                if (imem_req_valid && imem_req_ready) state_nx = F_WAIT;
            end
            F_WAIT: begin
                push = imem_rsp_valid && !flush;
                if (imem_rsp_valid) state_nx = F_IDLE;
                else if (flush) state_nx = F_KILL;
            end
            F_KILL: if (imem_rsp_valid) state_nx = F_IDLE;
            default: state_nx = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= F_IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= RESET_PC;
            head_pc    <= RESET_PC;
            drop_low   <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= flush_pc & ~32'd3;
            head_pc    <= flush_pc & ~32'd1;
            drop_low   <= flush_pc[1];
        end else begin
            if (accept) fetch_addr <= fetch_addr + 32'd4;
            if (pop) begin
                rd_ptr  <= is32 ? wrap_add(rd_ptr, 2) : rd_nx1;
                head_pc <= head_pc + (is32 ? 32'd4 : 32'd2);
            end
            if (push) begin
                wr_ptr   <= drop_low ? wr_nx1 : wrap_add(wr_ptr, 2);
                drop_low <= 1'b0;
            end
            count <= count + push_n - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (drop_low) q[wr_ptr] <= imem_rsp_data[31:16];
            else begin
                q[wr_ptr] <= imem_rsp_data[15:0];
                q[wr_nx1] <= imem_rsp_data[31:16];
            end
        end
    end
endmodule

// File: tb/tb_c_fetch_align_queue.sv
// tb_c_fetch_align_queue: directed bench for the fetch/align queue; the bench plays
// instruction memory by hand and checks each delivered instruction against constants.
module tb_c_fetch_align_queue;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_data, inst_pc;
    logic        inst_is_compressed;
    int          compared = 0;
    int          mismatched = 0;

    c_fetch_align_queue #(.DEPTH_HW(6), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .flush(flush), .flush_pc(flush_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_is_compressed(inst_is_compressed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        flush = 1'b0;
        inst_ready = 1'b0;
        adv();
        reset_n = 1'b1;
    endtask

    // Wait (bounded) for a request, check its address and accept it
    task automatic accept(input logic [31:0] a);
        int n = 0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        while (!imem_req_valid && n < 20) begin
            adv();
            @(negedge clk);
            n++;
        end
        chk("req_valid", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_addr, a);
        adv();
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = d;
        adv();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [31:0] d, input logic [31:0] pc, input logic c);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
        chk({tag, ".data"}, inst_data, d);
        chk({tag, ".pc"}, inst_pc, pc);
        chk({tag, ".c"}, 32'(inst_is_compressed), 32'(c));
        inst_ready = 1'b1;
        adv();
        inst_ready = 1'b0;
    endtask

    task automatic no_inst(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, 32'(inst_valid), 32'd0);
            adv();
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst.inst_valid", 32'(inst_valid), 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.data", inst_data, 32'h0);
        chk("rst.pc", inst_pc, 32'h0);
        chk("rst.c", 32'(inst_is_compressed), 32'd0);
        adv();
        reset_n = 1'b1;

        // two aligned 32-bit instructions
        accept(32'h0); respond(32'h0000_0013);
        accept(32'h4); respond(32'h0010_0093);
        take("t1a", 32'h0000_0013, 32'h0, 1'b0);
        take("t1b", 32'h0010_0093, 32'h4, 1'b0);

        // two compressed instructions in one word
        do_reset();
        accept(32'h0); respond(32'h0001_4501);
        take("t2a", 32'h0000_4501, 32'h0, 1'b1);
        take("t2b", 32'h0000_0001, 32'h2, 1'b1);

        // 32-bit instruction straddling a word boundary
        do_reset();
        accept(32'h0); respond(32'h0093_4505);
        take("t3a", 32'h0000_4505, 32'h0, 1'b1);
        no_inst("t3.split_wait", 1);
        accept(32'h4);
        no_inst("t3.split_wait", 2);
        respond(32'h0000_0200);
        take("t3b", 32'h0200_0093, 32'h2, 1'b0);

        // redirect with a request in flight: stale response dropped, upper half first
        do_reset();
        accept(32'h0);
        flush = 1'b1; flush_pc = 32'h0000_0102;
        @(negedge clk);
        chk("t4.req_in_flush", 32'(imem_req_valid), 32'd0);
        adv();
        flush = 1'b0;
        @(negedge clk);
        chk("t4.req_in_kill", 32'(imem_req_valid), 32'd0);
        adv();
        respond(32'hDEAD_BEEF);
        no_inst("t4.stale", 1);
        accept(32'h100); respond(32'h4501_ABCD);
        take("t4a", 32'h0000_4501, 32'h102, 1'b1);
        accept(32'h104); respond(32'h0000_0013);
        take("t4b", 32'h0000_0013, 32'h104, 1'b0);

        // backpressure fills the queue and stalls fetch without losing data
        do_reset();
        accept(32'h0); respond(32'h0000_0093);
        accept(32'h4); respond(32'h0010_0093);
        accept(32'h8); respond(32'h0020_0093);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5.full_stall", 32'(imem_req_valid), 32'd0);
            adv();
        end
        take("t5a", 32'h0000_0093, 32'h0, 1'b0);
        @(negedge clk);
        chk("t5.resume_req", 32'(imem_req_valid), 32'd1);
        chk("t5.resume_addr", imem_addr, 32'hC);
        adv();
        take("t5b", 32'h0010_0093, 32'h4, 1'b0);
        take("t5c", 32'h0020_0093, 32'h8, 1'b0);

        // flush coincident with a response and a pop
        do_reset();
        accept(32'h0); respond(32'h0001_4501);
        accept(32'h4);
        inst_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        flush = 1'b1; flush_pc = 32'h40;
        adv();
        inst_ready = 1'b0; imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t6.req_in_flush", 32'(imem_req_valid), 32'd0);
        chk("t6.inst_valid", 32'(inst_valid), 32'd0);
        chk("t6.pc", inst_pc, 32'h40);
        adv();
        flush = 1'b0;
        accept(32'h40); respond(32'h0000_4505);
        take("t6a", 32'h0000_4505, 32'h40, 1'b1);

        // redirect to the top halfword: fetch and PC both wrap to 0
        do_reset();
        flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
        adv();
        flush = 1'b0;
        accept(32'hFFFF_FFFC); respond(32'h4501_0000);
        take("t7a", 32'h0000_4501, 32'hFFFF_FFFE, 1'b1);
        accept(32'h0); respond(32'h0000_4505);
        take("t7b", 32'h0000_4505, 32'h0, 1'b1);

        // asynchronous reset mid-operation, late response ignored
        do_reset();
        accept(32'h0); respond(32'h0001_4501);
        accept(32'h4);
        #2 reset_n = 1'b0;
        #1;
        chk("t8.req_valid", 32'(imem_req_valid), 32'd0);
        chk("t8.inst_valid", 32'(inst_valid), 32'd0);
        chk("t8.addr", imem_addr, 32'h0);
        adv();
        reset_n = 1'b1;
        respond(32'h0000_0013);
        no_inst("t8.late_rsp", 1);
        accept(32'h0); respond(32'h0001_4501);
        take("t8a", 32'h0000_4501, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
